// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out stage: takes a WIDTH-bit word over valid/ready and emits one bit per clock.
// Build option PISO_PARITY_EN appends an even-parity bit to each frame (N = WIDTH+1 bits).
module piso_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             c_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             dbg_state
);

`ifdef PISO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(N - 2);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_out_q, c_out_d;
    logic             bv_q, bv_d;
    logic             fd_q, fd_d;

    logic             last_bit;
    logic             xfer;
    logic             first_bit;
    logic [WIDTH-1:0] rest_bits;
    logic             shift_bit;
    logic [WIDTH-1:0] sreg_adv;
    logic             next_bit;

    // Handshake: a word moves when load_valid && load_ready at a rising edge.
    // load_ready is combinational from state/counter, never from load_valid.
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
    assign xfer     = load_valid && load_ready;

    always_comb begin
        if (MSB_FIRST) begin
            first_bit = load_data[WIDTH-1];
            rest_bits = load_data << 1;
            shift_bit = sreg_q[WIDTH-1];
            sreg_adv  = sreg_q << 1;
        end else begin
            first_bit = load_data[0];
            rest_bits = load_data >> 1;
            shift_bit = sreg_q[0];
            sreg_adv  = sreg_q >> 1;
        end
    end

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
    logic par_q, par_d;

    assign par_d    = xfer ? ^load_data : par_q;
    // After the last data bit the parity captured with the word goes out.
    assign next_bit = (cnt_q == LAST_DATA) ? par_q : shift_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`else
    assign next_bit = shift_bit;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (xfer) state_d = S_SHIFT;
            S_SHIFT: if (last_bit && !xfer) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        load_ready = reset && ((state_q == S_IDLE) || last_bit);
        dbg_state  = state_q;
    end

    // Datapath next values
    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        c_out_d = c_out_q;
        bv_d    = bv_q;
        fd_d    = fd_q;
        if (xfer) begin
            c_out_d = first_bit;
            bv_d    = 1'b1;
            fd_d    = 1'b0;
            cnt_d   = '0;
            sreg_d  = rest_bits;
        end else if (last_bit) begin
            c_out_d = 1'b0;
            bv_d    = 1'b0;
            fd_d    = 1'b0;
            cnt_d   = '0;
            sreg_d  = '0;
        end else if (state_q == S_SHIFT) begin
            c_out_d = next_bit;
            cnt_d   = cnt_q + CW'(1);
            sreg_d  = sreg_adv;
            fd_d    = (cnt_q == PRE_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            c_out_q <= 1'b0;
            bv_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            c_out_q <= c_out_d;
            bv_q    <= bv_d;
            fd_q    <= fd_d;
        end
    end

    assign c_out      = c_out_q;
    assign bit_valid  = bv_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: MSB-first DUT plus an LSB-first DUT, scoreboard of expected bits.
// Honours PISO_PARITY_EN so the expected frames include the parity bit when it is defined.
module tb_piso_bit_serializer;

`ifdef PISO_PARITY_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready, c_out, bit_valid, frame_done, dbg_state;

    logic       lv_l = 1'b0;
    logic [7:0] ld_l = 8'h00;
    logic       lr_l, c_out_l, bv_l, fd_l, dbg_l;

    logic exp_q[$];
    logic exp_fd_q[$];
    logic exp_l_q[$];
    logic exp_l_fd_q[$];

    int   checks = 0;
    int   errors = 0;
    logic mready = 1'b0;
    logic accepted;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .c_out(c_out), .bit_valid(bit_valid),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load_valid(lv_l), .load_ready(lr_l),
        .load_data(ld_l), .c_out(c_out_l), .bit_valid(bv_l),
        .frame_done(fd_l), .dbg_state(dbg_l)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Emission order of a word, parity appended when enabled.
    task automatic frame_bits(input logic [7:0] w, input bit msb, output logic [8:0] bits);
        logic [7:0] tmp;
        tmp  = w;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[i] = msb ? tmp[7-i] : tmp[i];
        bits[8] = ^tmp;
    endtask

    task automatic push_main(input logic [7:0] w);
        logic [8:0] b;
        frame_bits(w, 1'b1, b);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(b[i]);
            exp_fd_q.push_back(i == N - 1);
        end
    endtask

    task automatic push_lsb(input logic [7:0] w);
        logic [8:0] b;
        frame_bits(w, 1'b0, b);
        for (int i = 0; i < N; i++) begin
            exp_l_q.push_back(b[i]);
            exp_l_fd_q.push_back(i == N - 1);
        end
    endtask

    task automatic check_cycle();
        logic b, f;
        if (!reset) begin
            chk("rst_c_out", c_out, 0);
            chk("rst_bit_valid", bit_valid, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_load_ready", load_ready, 0);
            chk("rst_lsb_bit_valid", bv_l, 0);
            mready = 1'b0;
        end else begin
            if (exp_q.size() == 0) begin
                chk("idle_c_out", c_out, 0);
                chk("idle_bit_valid", bit_valid, 0);
                chk("idle_frame_done", frame_done, 0);
                chk("idle_load_ready", load_ready, 1);
                mready = 1'b1;
            end else begin
                b = exp_q.pop_front();
                f = exp_fd_q.pop_front();
                chk("bit_valid", bit_valid, 1);
                chk("c_out", c_out, b);
                chk("frame_done", frame_done, f);
                chk("load_ready", load_ready, f);
                mready = f;
            end
            if (exp_l_q.size() == 0) begin
                chk("lsb_idle_bit_valid", bv_l, 0);
            end else begin
                b = exp_l_q.pop_front();
                f = exp_l_fd_q.pop_front();
                chk("lsb_bit_valid", bv_l, 1);
                chk("lsb_c_out", c_out_l, b);
                chk("lsb_frame_done", fd_l, f);
            end
        end
    endtask

    // Driver: record the transfer the model predicts, then let one edge happen and check.
    task automatic clk_step();
        if (load_valid && mready && reset) begin
            push_main(load_data);
            accepted = 1'b1;
        end
        if (lv_l && reset && exp_l_q.size() == 0) push_lsb(ld_l);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic send(input logic [7:0] w);
        load_valid = 1'b1;
        load_data  = w;
        accepted   = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) clk_step();
        chk("send_accepted", {31'd0, accepted}, 1);
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        load_data  = $urandom_range(0, 255);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    initial begin
        // Reset held for two cycles, then released with load_valid low
        reset = 1'b0;
        @(negedge clk);
        check_cycle();
        @(negedge clk);
        check_cycle();
        reset  = 1'b1;
        mready = 1'b1;
        idle(3);

        // Single transfer, then idle
        send(8'hB4);
        idle(N + 2);

        // Back-to-back frames with load_valid held high
        send(8'hFF);
        send(8'h01);
        idle(N + 2);

        // LSB-first instance
        lv_l = 1'b1;
        ld_l = 8'h01;
        clk_step();
        lv_l = 1'b0;
        ld_l = 8'hFF;
        idle(N + 2);

        // Asynchronous reset after the third bit of 8'hAA
        send(8'hAA);
        idle(2);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_c_out", c_out, 0);
        chk("async_rst_bit_valid", bit_valid, 0);
        chk("async_rst_load_ready", load_ready, 0);
        exp_q.delete();
        exp_fd_q.delete();
        mready = 1'b0;
        idle(2);
        reset  = 1'b1;
        mready = 1'b1;
        idle(N + 2);

        // Parity-relevant word, then a few random words with random gaps
        send(8'h07);
        idle(N + 1);
        for (int k = 0; k < 4; k++) begin
            send(8'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
        end
        idle(N + 2);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in, serial-out stage that feeds the serial input of the bit-sequence detector FSMs, such as the "more than one 1" detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on c_out.
- Qualifies each emitted bit with bit_valid and flags the last bit of each frame with frame_done.
- Supports gapless back-to-back frames.

Parameters:
- WIDTH, 8: data word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is emitted first; 0 = bit 0 is emitted first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_valid  input  1  upstream has a word on load_data.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word; captured only on handshake.
- c_out  output  1  serial data bit; connects to the detector's serial input.
- bit_valid  output  1  c_out carries a frame bit this cycle.
- frame_done  output  1  high during the last bit of a frame.

Behaviour:
- Reset (reset=0, asynchronous): immediately clear to state IDLE, shift register to 0, bit counter to 0; c_out=0, bit_valid=0, frame_done=0.
  - load_ready=0 while reset is low; load_ready=1 on the first cycle after release.
- States:
  - IDLE: load_ready=1, bit_valid=0, c_out=0.
  - SHIFT: emitting frame bits.
- Handshake: a transfer occurs on a rising edge when load_valid=1 and load_ready=1.
  - load_data is ignored whenever load_ready=0.
  - load_valid has no effect while the block is busy.
- Transfer at edge k:
  - c_out <= first bit (per MSB_FIRST); bit_valid <= 1.
  - Counter <= 0; remaining bits loaded into the shift register; state -> SHIFT.
- Each subsequent edge in SHIFT advances one bit: bit i of the frame is driven between edge k+i and edge k+i+1, for i = 0..N-1.
  - N = WIDTH, or WIDTH+1 with the optional feature.
- Counter width: $clog2(WIDTH+2). The counter increments per emitted bit and never wraps within a frame.
- Last-bit cycle (counter == N-1):
  - frame_done=1, registered, aligned with the last bit.
  - load_ready=1, derived combinationally from state and counter.
- Edge ending the last-bit cycle:
  - If load_valid=1: the new word is accepted; its first bit follows with no gap; state stays SHIFT; counter <= 0.
  - Else: state -> IDLE, c_out <= 0, bit_valid <= 0, frame_done <= 0.
- load_ready is 0 for every SHIFT cycle except the last-bit cycle. This gives a throughput of 1 word per N cycles with zero idle bits between frames.
- Latency: first bit visible 1 edge after the handshake edge; the last bit of a frame ends N edges after the handshake.
- Reset mid-frame: the frame is discarded; no residual bits appear after release.
- load_valid=1 held in IDLE: the word is accepted on the next edge, with no extra wait cycle.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit is emitted equal to the XOR of all bits of the captured word (even parity).
  - The parity value is computed and registered at capture; N = WIDTH+1.
  - frame_done and load_ready assert on the parity-bit cycle instead of the last data bit.
- Undefined: N = WIDTH; no parity logic is present.

Test Plan (WIDTH=8, MSB_FIRST=1 unless stated):
1. Hold reset=0 for 2 cycles, then release with load_valid=0 -> c_out=0, bit_valid=0, frame_done=0 throughout; load_ready=0 during reset and 1 after release.
2. Single transfer of 8'hB4 -> c_out = 1,0,1,1,0,1,0,0 on 8 consecutive cycles with bit_valid=1; frame_done=1 only on the 8th; then IDLE with bit_valid=0.
3. Back-to-back 8'hFF then 8'h01, load_valid held high -> 16 contiguous bits (eight 1s, then 0,0,0,0,0,0,0,1); bit_valid never drops; frame_done on bit cycles 8 and 16; load_ready high only on cycles 8 and 16.
4. MSB_FIRST=0, transfer 8'h01 -> c_out = 1 followed by seven 0s.
5. Transfer 8'hAA, then drive reset=0 asynchronously mid-cycle after the 3rd bit -> c_out and bit_valid drop to 0 immediately; after release the block is in IDLE and no remaining bits of 8'hAA appear.
6. PISO_PARITY_EN defined, transfer 8'h07 -> 9 bits: 0,0,0,0,0,1,1,1 then parity 1; frame_done on the 9th bit only.
